// File: rtl/mux_n_reg.sv
// mux_n_reg: registered N-way multiplexer with valid/ready handshaking on
// every input channel and on the output.
//
// Optional feature macro: MUX_N_REG_RR_EN
//   defined   -> round-robin arbitration plus a `ptr` register; mode=1 selects it
//   undefined -> `mode` is ignored and the block always uses explicit select
//
// Parameters:
//   WIDTH  data word width in bits
//   N      number of input channels
//   SELW   width of a channel index
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    packed channel words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, at most one bit high
//   sel        explicit channel index (used when mode=0)
//   mode       0 = explicit select, 1 = round-robin
//   out_data   registered selected word
//   out_chan   channel that produced out_data
//   out_valid  out_data/out_chan valid
//   out_ready  downstream accepts
module mux_n_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  input  logic               mode,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  logic            load;
  logic            sel_ok;
  logic            ex_vld;
  logic            gnt_vld;
  logic [SELW-1:0] gnt;

  // The output register may take a new word whenever it is empty or being
  // consumed this cycle, which gives back-to-back transfers without a bubble.
  assign load = !out_valid || out_ready;

  // Only a non power-of-two N can present an out-of-range select.
  generate
    if ((1 << SELW) > N) begin : g_sel_range
      assign sel_ok = (32'(sel) < N);
    end else begin : g_sel_full
      assign sel_ok = 1'b1;
    end
  endgenerate

  assign ex_vld = sel_ok && in_valid[sel];

`ifdef MUX_N_REG_RR_EN
  logic [SELW-1:0] ptr;
  logic            rr_vld;
  logic [SELW-1:0] rr_gnt;
  int unsigned     idx;

  // First valid channel searching upward from ptr+1, wrapping modulo N.
  always_comb begin
    rr_vld = 1'b0;
    rr_gnt = '0;
    idx    = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!rr_vld && in_valid[SELW'(idx)]) begin
        rr_vld = 1'b1;
        rr_gnt = SELW'(idx);
      end
    end
  end

  assign gnt_vld = mode ? rr_vld : ex_vld;
  assign gnt     = mode ? rr_gnt : sel;

  // Only round-robin transfers move the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= SELW'(N - 1);
    end else if (load && gnt_vld && mode) begin
      ptr <= gnt;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign gnt_vld     = ex_vld;
  assign gnt         = sel;
`endif

  // rst_n gating keeps every ready low while reset is asserted, even though
  // the emptied output register would otherwise allow a load.
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      in_ready[i] = rst_n && load && gnt_vld && (gnt == SELW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (load) begin
      if (gnt_vld) begin
        out_valid <= 1'b1;
        out_data  <= in_data[32'(gnt)*WIDTH +: WIDTH];
        out_chan  <= gnt;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
